chunk_adder: RTL and testbench

CHUNK_ADDER -- requirements
Module: chunk_adder

---
 rtl/chunk_adder_pkg.sv | 14 +
 rtl/chunk_adder_add_chunk.sv | 25 ++
 rtl/chunk_adder.sv | 119 +++++++++++
 tb/tb_chunk_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/chunk_adder_pkg.sv
// Shared types and constants for chunk_adder: FSM state encoding and chunk count.
package chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder_add_chunk.sv
// add_chunk: CHUNK-bit ripple-carry adder built from bitwise gates only.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder processing CHUNK bits per clock, LSB chunk first.
// Define CHUNK_ADDER_SUB_EN to add the op port (1 = subtract a - b).
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CHUNK_ADDER_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic             accept, last_chunk;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout, chunk_cmsb;
    logic [WIDTH-1:0] sum_nxt;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // the producer holds valid (and data) until then, ready never waits on valid.
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid & in_ready;
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

`ifdef CHUNK_ADDER_SUB_EN
    assign b_eff   = op ? ~b : b;
    assign cin_eff = op;
`else
    assign b_eff   = b;
    assign cin_eff = 1'b0;
`endif

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // The result is shifted in from the top so the final chunk lands in the MSBs.
    if (NCHUNK == 1) begin : g_single
        assign sum_nxt = chunk_sum;
    end else begin : g_multi
        assign sum_nxt = {chunk_sum, sum[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            idx     <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= chunk_cout;
            idx     <= idx + 1'b1;
            sum     <= sum_nxt;
            if (last_chunk) begin
                carry_out <= chunk_cout;
                overflow  <= chunk_cmsb ^ chunk_cout;
            end
        end
    end

endmodule

// File: tb/tb_chunk_adder.sv
// Bench for chunk_adder: randomized and directed operations against an arithmetic reference model.
module tb_chunk_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] a_i, b_i, sum;
    logic             op_i;
    logic             carry_out, overflow;

    logic             v32, rdy32, ov32, ordy32, co32, of32, op32;
    logic [WIDTH-1:0] a32, b32, s32;

    int total = 0;
    int bad   = 0;

    chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
`ifdef CHUNK_ADDER_SUB_EN
        .op        (op_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    chunk_adder #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v32),
        .in_ready  (rdy32),
        .a         (a32),
        .b         (b32),
`ifdef CHUNK_ADDER_SUB_EN
        .op        (op32),
`endif
        .out_valid (ov32),
        .out_ready (ordy32),
        .sum       (s32),
        .carry_out (co32),
        .overflow  (of32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision arithmetic, signed-overflow from operand/result signs.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic sub,
                         output logic [31:0] s, output logic c, output logic v);
        logic [32:0] r;
        if (sub) begin
            r = {1'b0, x} - {1'b0, y};
            s = r[31:0];
            c = (x >= y);
            v = (x[31] != y[31]) && (s[31] != x[31]);
        end else begin
            r = {1'b0, x} + {1'b0, y};
            s = r[31:0];
            c = r[32];
            v = (x[31] == y[31]) && (s[31] != x[31]);
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                          input int hold);
        logic [31:0] es;
        logic        ec, ev;
        int          lat;
        model(x, y, sub, es, ec, ev);
        check("in_ready_idle", in_ready, 1);
        a_i = x; b_i = y; op_i = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 64) begin
            in_valid = 1'($urandom_range(0, 1));
            a_i = $urandom; b_i = $urandom; op_i = ~sub;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, NCHUNK);
        check("sum", sum, es);
        check("carry_out", carry_out, ec);
        check("overflow", overflow, ev);
        check("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_i = $urandom;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, es);
            check("hold_carry", carry_out, ec);
            check("hold_ovf", overflow, ev);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] es;
        logic        ec, ev;
        int          lat;
        model(x, y, 1'b0, es, ec, ev);
        check("w32_in_ready", rdy32, 1);
        a32 = x; b32 = y; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32_latency", lat, 1);
        check("w32_sum", s32, es);
        check("w32_carry", co32, ec);
        check("w32_ovf", of32, ev);
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
        check("w32_post_hs", ov32, 0);
    endtask

    initial begin
        logic sub;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; op_i = 1'b0;
        v32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0; op32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry_out, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 3);
`ifdef CHUNK_ADDER_SUB_EN
        run_op(32'd5, 32'd7, 1'b1, 0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 0);
        run_op(32'd7, 32'd7, 1'b1, 1);
`endif

        // Reset while in RUN cycle 2 abandons the operation.
        a_i = 32'hFFFF_FFFF; b_i = 32'h1; op_i = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry_out, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
`ifdef CHUNK_ADDER_SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            run_op($urandom, $urandom, sub, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        run32(32'h8000_0000, 32'h8000_0000);
        run32(32'hFFFF_FFFF, 32'h0000_0001);
        for (int i = 0; i < 10; i++) begin
            run32($urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
